// File: rtl/timer_pkg.sv
// timer_pkg: shared state encoding and mode constants for the multi-channel timer
package timer_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
    localparam logic ONESHOT  = 1'b0;
    localparam logic PERIODIC = 1'b1;
endpackage

// File: rtl/timer_ch.sv
// timer_ch: one independent timer/PWM channel with shadowed period, duty, mode and polarity
module timer_ch
    import timer_pkg::*;
#(
    parameter int CW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mode,
    input  logic          go_en,
    input  logic [CW-1:0] tot,
    input  logic [CW-1:0] duty,
    input  logic          pol,
    output logic          irq,
    output logic          pwm,
    output logic          busy
);
    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt, sh_tot, sh_duty;
    logic          sh_mode, sh_pol, load, run, at_end;
    assign run    = (state == RUN) && go_en;
    assign at_end = cnt == sh_tot;
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (go_en) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                    load      = 1'b1;
                end
            end
            RUN: begin
                // a dropped enable wins over a period end, so no pulse escapes
                if (!go_en) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (at_end) begin
                    cnt_nxt   = '0;
                    load      = sh_mode == PERIODIC;
                    state_nxt = sh_mode == PERIODIC ? RUN : DONE;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            DONE:    state_nxt = go_en ? DONE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            sh_tot  <= '0;
            sh_duty <= '0;
            sh_mode <= 1'b0;
            sh_pol  <= 1'b0;
            irq     <= 1'b0;
            pwm     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            irq   <= run && at_end;
            pwm   <= run ? ((cnt < sh_duty) ^ sh_pol) : pol;
            busy  <= run;
            if (load) begin
                sh_tot  <= tot;
                sh_duty <= duty;
                sh_mode <= mode;
                sh_pol  <= pol;
            end
        end
    end
endmodule

// File: rtl/multi_timer.sv
// multi_timer: NCH independent timer/PWM channels; the top only slices the packed buses
module multi_timer
    import timer_pkg::*;
#(
    parameter int NCH = 4,
    parameter int CW  = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [NCH-1:0]    MODE,
    input  logic [NCH-1:0]    GO_EN,
    input  logic [NCH*CW-1:0] TOT_CNT,
    input  logic [NCH*CW-1:0] DUTY_CNT,
    input  logic [NCH-1:0]    POL,
    output logic [NCH-1:0]    IRQ_TRG,
    output logic [NCH-1:0]    PWM,
    output logic [NCH-1:0]    BUSY
);
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        timer_ch #(.CW(CW)) u_ch (
            .clk  (CLK),
            .rst  (RST),
            .mode (MODE[i]),
            .go_en(GO_EN[i]),
            .tot  (TOT_CNT[i*CW +: CW]),
            .duty (DUTY_CNT[i*CW +: CW]),
            .pol  (POL[i]),
            .irq  (IRQ_TRG[i]),
            .pwm  (PWM[i]),
            .busy (BUSY[i])
        );
    end
endmodule

// File: doc/multi_timer.md
MULTI_TIMER -- requirements
Module: multi_timer

Interface
REQ-001 Parameter NCH, default 4, number of independent timer/PWM channels (1..16) SHALL be supported.
REQ-002 Parameter CW, default 32, counter/compare width in bits (8..32) SHALL be supported.
REQ-003 Port CLK  input  1  sole clock; all state SHALL update on rising edge.
REQ-004 Port RST  input  1  asynchronous, active-high reset.
REQ-005 Port MODE  input  NCH  per channel: 0 = one-shot, 1 = periodic.
REQ-006 Port GO_EN  input  NCH  per channel run enable (level).
REQ-007 Port TOT_CNT  input  NCH*CW  per channel period compare; channel i at bits [i*CW +: CW].
REQ-008 Port DUTY_CNT  input  NCH*CW  per channel duty compare; same packing.
REQ-009 Port POL  input  NCH  per channel PWM polarity: 0 = active-high, 1 = active-low.
REQ-010 Port IRQ_TRG  output  NCH  per channel one-cycle period-end pulse.
REQ-011 Port PWM  output  NCH  per channel PWM waveform.
REQ-012 Port BUSY  output  NCH  per channel high while in RUN.

Function
REQ-013 Each channel SHALL be fully independent; no shared counter or arbitration.
REQ-014 Each channel SHALL implement states IDLE, RUN, DONE.
REQ-015 IDLE->RUN on the first cycle GO_EN[i] is sampled high; shadow TOT/DUTY/MODE/POL SHALL be loaded from inputs and counter cleared to 0 on that edge.
REQ-016 In RUN, counter SHALL increment by 1 each cycle from 0 to shadow TOT inclusive; period = TOT+1 cycles; TOT=0 gives a 1-cycle period.
REQ-017 Active PWM level SHALL be asserted while in RUN and counter < shadow DUTY; DUTY=0 -> never active; DUTY > TOT -> active whole period.
REQ-018 PWM output SHALL equal active level XOR shadow POL; in IDLE/DONE PWM SHALL equal POL input (inactive level).
REQ-019 PWM, IRQ_TRG, BUSY SHALL be registered; each reflects counter/state of the previous cycle (1-cycle latency).
REQ-020 IRQ_TRG[i] SHALL pulse exactly one cycle per completed period, in the cycle after counter == shadow TOT.
REQ-021 Periodic: at counter == TOT, counter SHALL wrap to 0 and shadows SHALL reload from current inputs; mid-period input changes SHALL NOT affect the running period.
REQ-022 One-shot: at counter == TOT, channel SHALL go to DONE; DONE->IDLE only when GO_EN[i] sampled low; re-arm requires a low-then-high GO_EN.
REQ-023 GO_EN[i] low in RUN SHALL return to IDLE next edge, counter cleared, no IRQ_TRG, even if counter == TOT in that cycle.
REQ-024 Counter arithmetic SHALL be CW-bit unsigned; comparison SHALL be unsigned; TOT = 2^CW-1 SHALL not overflow before the period end.

Reset
REQ-025 RST high SHALL asynchronously force all channels to IDLE, counters and shadows to 0, IRQ_TRG=0, BUSY=0, PWM=0.
REQ-026 Reset release SHALL be synchronous-safe; first channel start occurs no earlier than the first edge with RST low and GO_EN high.
REQ-027 Reset asserted mid-period SHALL abort without IRQ_TRG pulse.

Structure
REQ-028 Package timer_pkg SHALL hold state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and MODE constants (ONESHOT=0, PERIODIC=1).
REQ-029 One sub-module timer_ch (single channel, parameter CW) SHALL be instantiated NCH times by a generate loop; top holds only slicing.

Verification
REQ-030 CW=8, ch0 periodic TOT=9 DUTY=3 POL=0 -> PWM high 3/low 7 cycles, IRQ_TRG pulse every 10 cycles, BUSY high.
REQ-031 ch1 one-shot TOT=4 DUTY=2 -> one IRQ_TRG pulse 5 cycles after start, DONE, PWM inactive, no further pulse until GO_EN toggled.
REQ-032 ch0 periodic TOT=9, change TOT to 4 at counter=5 -> current period completes at 10 cycles, next periods 5 cycles.
REQ-033 DUTY=0 -> PWM never active; DUTY=20, TOT=9 -> PWM active all RUN cycles; POL=1 inverts both.
REQ-034 GO_EN dropped at counter == TOT, and separately RST pulsed mid-period -> no IRQ_TRG, IDLE, PWM inactive next cycle.
REQ-035 All 4 channels running different TOT simultaneously -> each IRQ_TRG period matches its own TOT+1 with no cross-coupling.
